// File: rtl/tta_icache.sv
// ---------------------------------------------------------------------------
// tta_icache
//   Direct-mapped instruction cache that answers the TTA program counter.
//   Lookup is combinational, so a hit acks in the same cycle as the fetch.
//   On a miss the line is filled from external memory one word at a time.
//   After the last word is written, hit_o pulses once so the PC can retry.
//
// Ports
//   clock_i      rising-edge clock
//   reset_ni     asynchronous active-low reset
//   fetch_i      PC requests the instruction at pc_i
//   pc_i         instruction word address
//   ack_o        instr_o is valid for pc_i this cycle
//   hit_o        one-cycle pulse when the missed line becomes resident
//   instr_o      instruction word read from the cache
//   flush_i      invalidate every line on the next edge
//   mem_req_o    line-fill request, held until mem_ack_i
//   mem_addr_o   line-aligned fill address
//   mem_ack_i    memory accepted the request
//   mem_valid_i  mem_data_i carries the next fill word
//   mem_data_i   fill data, words in ascending order
// ---------------------------------------------------------------------------
module tta_icache #(
  parameter int WIDTH      = 18,
  parameter int DATA       = 32,
  parameter int LINE_BITS  = 2,
  parameter int INDEX_BITS = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             fetch_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             ack_o,
  output logic             hit_o,
  output logic [DATA-1:0]  instr_o,
  input  logic             flush_i,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  input  logic             mem_ack_i,
  input  logic             mem_valid_i,
  input  logic [DATA-1:0]  mem_data_i
);

  localparam int TAG_BITS = WIDTH - INDEX_BITS - LINE_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << LINE_BITS;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  // Storage: only the valid bits need a reset value.
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [DATA-1:0]     r_data [LINES*WORDS];

  // Fill bookkeeping
  logic [INDEX_BITS-1:0] r_lineIdx;
  logic [TAG_BITS-1:0]   r_lineTag;
  logic [LINE_BITS-1:0]  r_count;
  logic                  r_flushed;

  logic [INDEX_BITS-1:0] w_idx;
  logic [LINE_BITS-1:0]  w_word;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fillWrite;
  logic [LINE_BITS-1:0]  w_fillWord;
  logic                  w_lastWord;

  // Address split and combinational lookup
  always_comb begin
    w_idx   = pc_i[LINE_BITS +: INDEX_BITS];
    w_word  = pc_i[LINE_BITS-1:0];
    w_tag   = pc_i[WIDTH-1 -: TAG_BITS];
    w_hit   = fetch_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    w_miss  = fetch_i & ~w_hit;
    ack_o   = w_hit;
    instr_o = r_data[{w_idx, w_word}];
  end

  // Fill-word strobe. A word that arrives together with mem_ack_i is word 0.
  always_comb begin
    w_fillWrite = mem_valid_i &
                  ((r_state == FILL) | ((r_state == REQ) & mem_ack_i));
    w_fillWord  = (r_state == FILL) ? r_count : '0;
    w_lastWord  = mem_valid_i & (r_state == FILL) &
                  (r_count == {LINE_BITS{1'b1}});
  end

  // State register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; misses outside IDLE are ignored because the PC holds.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_miss)     w_nextState = REQ;
      REQ:     if (mem_ack_i)  w_nextState = FILL;
      FILL:    if (w_lastWord) w_nextState = DONE;
      DONE:                    w_nextState = IDLE;
      default:                 w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req_o = (r_state == REQ);
    hit_o     = (r_state == DONE);
  end

  assign mem_addr_o = {r_lineTag, r_lineIdx, {LINE_BITS{1'b0}}};

  // Fill control and valid bits. A flush seen at any point of a fill,
  // including the cycle that starts it or writes its last word, keeps the
  // filled line invalid so the PC misses again.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_valid   <= '0;
      r_lineIdx <= '0;
      r_lineTag <= '0;
      r_count   <= '0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_lineIdx <= w_idx;
            r_lineTag <= w_tag;
            r_count   <= '0;
            r_flushed <= flush_i;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            r_count <= LINE_BITS'(mem_valid_i);
          end
          if (flush_i) begin
            r_flushed <= 1'b1;
          end
        end
        FILL: begin
          if (mem_valid_i) begin
            r_count <= r_count + 1'b1;
          end
          if (flush_i) begin
            r_flushed <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      if (flush_i) begin
        r_valid <= '0;
      end else begin
        if ((r_state == IDLE) && w_miss) begin
          r_valid[w_idx] <= 1'b0;
        end
        if (w_lastWord && !r_flushed) begin
          r_valid[r_lineIdx] <= 1'b1;
        end
      end
    end
  end

  // Tag and data arrays
  always_ff @(posedge clock_i) begin
    if (w_fillWrite) begin
      r_data[{r_lineIdx, w_fillWord}] <= mem_data_i;
    end
    if (w_lastWord) begin
      r_tag[r_lineIdx] <= r_lineTag;
    end
  end

endmodule

// File: tb/tb_tta_icache.sv
// ---------------------------------------------------------------------------
// tb_tta_icache
//   Directed bench for tta_icache. It plays the memory side of the line
//   fill and compares the cache outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_tta_icache;

  logic        clock_i;
  logic        reset_ni;
  logic        fetch_i;
  logic [17:0] pc_i;
  logic        ack_o;
  logic        hit_o;
  logic [31:0] instr_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [17:0] mem_addr_o;
  logic        mem_ack_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  int checks;
  int errors;
  int hitCount;
  int hitBefore;

  tta_icache dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .fetch_i     (fetch_i),
    .pc_i        (pc_i),
    .ack_o       (ack_o),
    .hit_o       (hit_o),
    .instr_o     (instr_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i)
  );

  // 10-unit clock
  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Count hit_o pulses away from the active edge
  initial hitCount = 0;
  always @(negedge clock_i) begin
    if (hit_o === 1'b1) hitCount++;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a fetch and let the combinational lookup settle
  task automatic applyStimulus(input logic fetch, input logic [17:0] pc);
    fetch_i = fetch;
    pc_i    = pc;
    #1;
  endtask

  // Memory side of one line fill. Returns in the DONE cycle.
  task automatic serveFill(input logic [17:0] expAddr, input logic [31:0] base,
                           input int ackDelay, input bit gaps,
                           input bit dataWithAck, input int flushWord);
    int budget;
    int sent;
    budget = 0;
    while (mem_req_o !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput("memReq", mem_req_o, 1);
    checkOutput("memAddr", mem_addr_o, expAddr);
    if (mem_req_o !== 1'b1) return;
    for (int d = 0; d < ackDelay; d++) begin
      tick();
      checkOutput("memReqHold", mem_req_o, 1);
      checkOutput("memAddrHold", mem_addr_o, expAddr);
    end
    mem_ack_i   = 1'b1;
    mem_valid_i = dataWithAck;
    mem_data_i  = base;
    sent        = dataWithAck ? 1 : 0;
    tick();
    mem_ack_i   = 1'b0;
    mem_valid_i = 1'b0;
    checkOutput("memReqDrop", mem_req_o, 0);
    while (sent < 4) begin
      if (gaps) begin
        mem_valid_i = 1'b0;
        mem_data_i  = 32'hBAD0_0000;
        tick();
      end
      mem_valid_i = 1'b1;
      mem_data_i  = base + 32'(sent);
      flush_i     = (sent == flushWord);
      tick();
      sent++;
      mem_valid_i = 1'b0;
      flush_i     = 1'b0;
    end
    checkOutput("hitPulse", hit_o, 1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_ni    = 1'b0;
    fetch_i     = 1'b0;
    pc_i        = '0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;

    // Reset state
    tick();
    tick();
    applyStimulus(1'b1, 18'h00010);
    checkOutput("resetReq", mem_req_o, 0);
    checkOutput("resetHit", hit_o, 0);
    checkOutput("resetAddr", mem_addr_o, 0);
    checkOutput("resetAck", ack_o, 0);

    // 1: cold miss
    $display("[TB] cold miss");
    reset_ni = 1'b1;
    #1;
    checkOutput("coldAck", ack_o, 0);
    tick();
    hitBefore = hitCount;
    serveFill(18'h00010, 32'hA0, 0, 1'b0, 1'b1, -1);
    checkOutput("coldFillAck", ack_o, 1);
    tick();
    checkOutput("coldHitOnce", hitCount - hitBefore, 1);
    checkOutput("coldHitLow", hit_o, 0);
    checkOutput("coldAckAfter", ack_o, 1);
    checkOutput("coldInstr", instr_o, 32'hA0);

    // 2: sequential hits, with stray mem_valid_i that must be ignored
    $display("[TB] sequential hits");
    mem_valid_i = 1'b1;
    mem_data_i  = 32'hDEAD;
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 18'h00010 + 18'(i));
      checkOutput("seqAck", ack_o, 1);
      checkOutput("seqInstr", instr_o, 32'hA0 + 32'(i));
      tick();
      checkOutput("seqNoReq", mem_req_o, 0);
    end
    mem_valid_i = 1'b0;
    applyStimulus(1'b1, 18'h00010);
    checkOutput("strayIgnored", instr_o, 32'hA0);

    // 3: conflict miss on the same index
    $display("[TB] conflict miss");
    applyStimulus(1'b1, 18'h00050);
    checkOutput("conflictAck", ack_o, 0);
    tick();
    serveFill(18'h00050, 32'hB0, 0, 1'b0, 1'b1, -1);
    tick();
    checkOutput("conflictInstr", instr_o, 32'hB0);
    applyStimulus(1'b1, 18'h00010);
    checkOutput("evictedAck", ack_o, 0);
    tick();
    serveFill(18'h00010, 32'hC0, 0, 1'b0, 1'b1, -1);
    tick();
    applyStimulus(1'b1, 18'h00012);
    checkOutput("refillAck", ack_o, 1);
    checkOutput("refillInstr", instr_o, 32'hC2);

    // 4: delayed ack and gappy data
    $display("[TB] delayed ack");
    applyStimulus(1'b1, 18'h00030);
    tick();
    hitBefore = hitCount;
    serveFill(18'h00030, 32'hD0, 5, 1'b1, 1'b0, -1);
    tick();
    tick();
    checkOutput("gapHitOnce", hitCount - hitBefore, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 18'h00030 + 18'(i));
      checkOutput("gapInstr", instr_o, 32'hD0 + 32'(i));
    end

    // 5: flush during fill
    $display("[TB] flush during fill");
    applyStimulus(1'b1, 18'h00020);
    tick();
    hitBefore = hitCount;
    serveFill(18'h00020, 32'hE0, 0, 1'b0, 1'b1, 1);
    checkOutput("flushDoneAck", ack_o, 0);
    tick();
    checkOutput("flushHitOnce", hitCount - hitBefore, 1);
    checkOutput("flushAck", ack_o, 0);
    tick();
    checkOutput("flushRefetchReq", mem_req_o, 1);
    checkOutput("flushRefetchAddr", mem_addr_o, 18'h00020);
    applyStimulus(1'b1, 18'h00010);
    checkOutput("flushOtherAck", ack_o, 0);
    applyStimulus(1'b1, 18'h00020);
    serveFill(18'h00020, 32'hE8, 0, 1'b0, 1'b1, -1);
    tick();
    checkOutput("flushRefillAck", ack_o, 1);
    checkOutput("flushRefillInstr", instr_o, 32'hE8);

    // Top-of-memory line
    $display("[TB] line wrap");
    applyStimulus(1'b1, 18'h3FFFE);
    tick();
    serveFill(18'h3FFFC, 32'h50, 0, 1'b0, 1'b1, -1);
    tick();
    checkOutput("wrapAck", ack_o, 1);
    checkOutput("wrapInstr", instr_o, 32'h52);

    // 6: reset mid-fill
    $display("[TB] reset mid-fill");
    applyStimulus(1'b1, 18'h00010);
    checkOutput("preResetAck", ack_o, 0);
    tick();
    checkOutput("preResetReq", mem_req_o, 1);
    mem_ack_i   = 1'b1;
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h11;
    tick();
    mem_ack_i   = 1'b0;
    mem_data_i  = 32'h12;
    tick();
    mem_valid_i = 1'b0;
    reset_ni    = 1'b0;
    #1;
    checkOutput("midResetReq", mem_req_o, 0);
    checkOutput("midResetHit", hit_o, 0);
    checkOutput("midResetAddr", mem_addr_o, 0);
    applyStimulus(1'b1, 18'h00020);
    checkOutput("midResetOtherAck", ack_o, 0);
    applyStimulus(1'b1, 18'h00010);
    tick();
    reset_ni = 1'b1;
    #1;
    checkOutput("postResetAck", ack_o, 0);
    tick();
    serveFill(18'h00010, 32'hF0, 0, 1'b0, 1'b1, -1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 18'h00010 + 18'(i));
      checkOutput("restartAck", ack_o, 1);
      checkOutput("restartInstr", instr_o, 32'hF0 + 32'(i));
    end

    fetch_i = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
